// File: rtl/interp_lin_ratio_if.sv
// Sample-in / interpolated-out bundle for interp_lin_ratio.
// The source drives in_data/in_valid; the interpolator drives everything else.
interface interp_lin_ratio_if #(
  parameter int IN_W  = 15,
  parameter int OUT_W = 18
);
  logic signed [IN_W-1:0]  in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    seg_start;
  logic                    underrun;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  seg_start,
    input  underrun
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    output seg_start,
    output underrun
  );
endinterface

// File: rtl/interp_lin_ratio.sv
// Linear / zero-order-hold upsampler by 2^LOG2_RATIO with a one-deep input buffer.
// On underrun it holds the last sample (flat segment) rather than extrapolating.
module interp_lin_ratio #(
  parameter int IN_W       = 15,
  parameter int LOG2_RATIO = 3,
  parameter int OUT_W      = 18
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              mode,
  input  logic              flush,
  interp_lin_ratio_if.slave bus
);

  localparam int ACC_W  = IN_W + LOG2_RATIO + 1;
  localparam int STEP_W = IN_W + 1;
  localparam logic [LOG2_RATIO-1:0] PH_LAST = {LOG2_RATIO{1'b1}};
  localparam logic [LOG2_RATIO-1:0] PH_ONE  = LOG2_RATIO'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                    r_state_r;
  logic signed [IN_W-1:0]    r_cur_r;
  logic signed [IN_W-1:0]    r_prev_r;
  logic signed [IN_W-1:0]    r_buf_r;
  logic                      r_buf_vld_r;
  logic signed [ACC_W-1:0]   r_acc_r;
  logic signed [STEP_W-1:0]  r_step_r;
  logic [LOG2_RATIO-1:0]     r_ph_r;
  logic                      r_mode_q_r;
  logic signed [OUT_W-1:0]   r_out_data_r;
  logic                      r_out_valid_r;
  logic                      r_seg_start_r;
  logic                      r_underrun_r;

  logic                      w_in_ready_s;
  logic                      w_accept_s;
  logic                      w_wrap_s;
  logic                      w_prime_load_s;
  logic                      w_load_s;
  logic signed [IN_W-1:0]    w_new_cur_s;
  logic signed [IN_W-1:0]    w_new_prev_s;
  logic                      w_mode_eff_s;
  logic signed [STEP_W-1:0]  w_seg_step_s;
  logic signed [ACC_W-1:0]   w_seg_base_s;

  // Exact segment slope: one extra bit so the full-scale difference never truncates.
  function automatic logic signed [STEP_W-1:0] seg_diff(
    input logic signed [IN_W-1:0] a,
    input logic signed [IN_W-1:0] b
  );
    seg_diff = {b[IN_W-1], b} - {a[IN_W-1], a};
  endfunction

  function automatic logic signed [ACC_W-1:0] seg_base(input logic signed [IN_W-1:0] p);
    seg_base = {p[IN_W-1], p, {LOG2_RATIO{1'b0}}};
  endfunction

  function automatic logic signed [ACC_W-1:0] step_ext(input logic signed [STEP_W-1:0] s);
    step_ext = {{LOG2_RATIO{s[STEP_W-1]}}, s};
  endfunction

  // Handshake, wrap detection and the values a segment load would take.
  always_comb begin
    w_in_ready_s   = 1'b1;
    w_new_cur_s    = r_buf_r;
    w_new_prev_s   = r_prev_r;
    w_mode_eff_s   = r_mode_q_r;
    w_seg_step_s   = {STEP_W{1'b0}};
    if (r_state_r == ST_RUN) begin
      w_in_ready_s = ~r_buf_vld_r;
    end else begin
      w_in_ready_s = 1'b1;
    end
    w_accept_s     = bus.in_valid & w_in_ready_s;
    w_wrap_s       = (r_state_r == ST_RUN) & tick & (r_ph_r == PH_LAST);
    w_prime_load_s = (r_state_r == ST_PRIME) & w_accept_s;
    w_load_s       = w_prime_load_s | (w_wrap_s & r_buf_vld_r);
    if (w_prime_load_s) begin
      w_new_cur_s = bus.in_data;
    end else begin
      w_new_cur_s = r_buf_r;
    end
    // Every load and every flat (underrun) wrap retires cur into prev.
    if (w_load_s | w_wrap_s) begin
      w_new_prev_s = r_cur_r;
    end else begin
      w_new_prev_s = r_prev_r;
    end
    if (w_load_s) begin
      w_mode_eff_s = mode;
    end else begin
      w_mode_eff_s = r_mode_q_r;
    end
    if (w_load_s & w_mode_eff_s) begin
      w_seg_step_s = seg_diff(r_cur_r, w_new_cur_s);
    end else begin
      w_seg_step_s = {STEP_W{1'b0}};
    end
    w_seg_base_s = seg_base(r_cur_r);
  end

  // Control FSM, segment accumulator and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state_r     <= ST_IDLE;
      r_cur_r       <= {IN_W{1'b0}};
      r_prev_r      <= {IN_W{1'b0}};
      r_buf_r       <= {IN_W{1'b0}};
      r_buf_vld_r   <= 1'b0;
      r_acc_r       <= {ACC_W{1'b0}};
      r_step_r      <= {STEP_W{1'b0}};
      r_ph_r        <= {LOG2_RATIO{1'b0}};
      r_mode_q_r    <= 1'b0;
      r_out_data_r  <= {OUT_W{1'b0}};
      r_out_valid_r <= 1'b0;
      r_seg_start_r <= 1'b0;
      r_underrun_r  <= 1'b0;
    end else if (flush) begin
      r_state_r     <= ST_IDLE;
      r_buf_vld_r   <= 1'b0;
      r_acc_r       <= {ACC_W{1'b0}};
      r_step_r      <= {STEP_W{1'b0}};
      r_ph_r        <= {LOG2_RATIO{1'b0}};
      r_out_data_r  <= {OUT_W{1'b0}};
      r_out_valid_r <= 1'b0;
      r_seg_start_r <= 1'b0;
      r_underrun_r  <= 1'b0;
    end else begin
      r_out_valid_r <= 1'b0;
      r_seg_start_r <= 1'b0;
      r_underrun_r  <= 1'b0;
      r_prev_r      <= w_new_prev_s;
      r_mode_q_r    <= w_mode_eff_s;
      case (r_state_r)
        ST_IDLE: begin
          if (w_accept_s) begin
            r_cur_r   <= bus.in_data;
            r_state_r <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          if (w_accept_s) begin
            r_cur_r   <= bus.in_data;
            r_acc_r   <= w_seg_base_s;
            r_step_r  <= w_seg_step_s;
            r_ph_r    <= {LOG2_RATIO{1'b0}};
            r_state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            r_out_data_r  <= r_acc_r[IN_W+LOG2_RATIO-1 -: OUT_W];
            r_out_valid_r <= 1'b1;
            r_seg_start_r <= (r_ph_r == {LOG2_RATIO{1'b0}});
            r_ph_r        <= r_ph_r + PH_ONE;
            if (w_wrap_s) begin
              r_acc_r <= w_seg_base_s;
              if (r_buf_vld_r) begin
                r_cur_r     <= r_buf_r;
                r_step_r    <= w_seg_step_s;
                r_buf_vld_r <= 1'b0;
              end else begin
                r_step_r     <= {STEP_W{1'b0}};
                r_underrun_r <= 1'b1;
              end
            end else begin
              r_acc_r <= r_acc_r + step_ext(r_step_r);
            end
          end
          // Placed after the drain so a same-cycle accept keeps the buffer full.
          if (w_accept_s) begin
            r_buf_r     <= bus.in_data;
            r_buf_vld_r <= 1'b1;
          end
        end
        default: begin
          r_state_r   <= ST_IDLE;
          r_buf_vld_r <= 1'b0;
          r_ph_r      <= {LOG2_RATIO{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready_s;
  assign bus.out_data  = r_out_data_r;
  assign bus.out_valid = r_out_valid_r;
  assign bus.seg_start = r_seg_start_r;
  assign bus.underrun  = r_underrun_r;

endmodule
